// File: rtl/picorv32_axi_sram_pkg.sv
// rtl/picorv32_axi_sram_pkg.sv - shared response codes and arbiter grant type
package picorv32_axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WR   = 2'd1,
        GRANT_RD   = 2'd2
    } grant_t;

endpackage

// File: rtl/picorv32_axi_sram_array.sv
// rtl/picorv32_axi_sram_array.sv - single-port byte-strobed synchronous RAM
module picorv32_axi_sram_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // rdata only moves on reads so a pending read response survives later writes
    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/picorv32_axi_sram.sv
// rtl/picorv32_axi_sram.sv - AXI4-lite slave over on-chip SRAM; PICORV32_AXI_SRAM_DECERR_EN enables range decode errors
module picorv32_axi_sram
    import picorv32_axi_sram_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    output logic [1:0]  mem_axi_bresp,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic [1:0]  mem_axi_rresp
);

    localparam int AW = $clog2(MEM_WORDS);

    logic        aw_full, w_full, ar_full, prio_rd, r_hit;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    logic        wr_elig, rd_elig, wr_hit, rd_hit;
    logic [31:0] wr_off, rd_off;
    grant_t      grant;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign mem_axi_awready = !aw_full;
    assign mem_axi_wready  = !w_full;
    assign mem_axi_arready = !ar_full;

    assign wr_elig = aw_full && w_full && !mem_axi_bvalid;
    assign rd_elig = ar_full && !mem_axi_rvalid;
    assign wr_off  = aw_addr - BASE_ADDR;
    assign rd_off  = ar_addr - BASE_ADDR;

`ifdef PICORV32_AXI_SRAM_DECERR_EN
    assign wr_hit = wr_off < 32'(4 * MEM_WORDS);
    assign rd_hit = rd_off < 32'(4 * MEM_WORDS);
`else
    assign wr_hit = 1'b1;
    assign rd_hit = 1'b1;
`endif

    always_comb begin
        grant = GRANT_NONE;
        if (wr_elig && rd_elig) begin
            grant = prio_rd ? GRANT_RD : GRANT_WR;
        end else if (wr_elig) begin
            grant = GRANT_WR;
        end else if (rd_elig) begin
            grant = GRANT_RD;
        end
    end

    // Upper offset bits are dropped here, which gives the aliasing of the default build
    assign ram_en   = (grant == GRANT_WR && wr_hit && (w_strb != 4'b0000)) ||
                      (grant == GRANT_RD && rd_hit);
    assign ram_we   = (grant == GRANT_WR && wr_hit) ? w_strb : 4'b0000;
    assign ram_addr = (grant == GRANT_WR) ? wr_off[AW+1:2] : rd_off[AW+1:2];

    picorv32_axi_sram_array #(.WORDS(MEM_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (ram_rdata)
    );

    assign mem_axi_rdata = r_hit ? ram_rdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
            ar_full        <= 1'b0;
            aw_addr        <= 32'h0;
            w_data         <= 32'h0;
            w_strb         <= 4'h0;
            ar_addr        <= 32'h0;
            mem_axi_bvalid <= 1'b0;
            mem_axi_bresp  <= RESP_OKAY;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rresp  <= RESP_OKAY;
            r_hit          <= 1'b0;
            prio_rd        <= 1'b0;
        end else begin
            if (mem_axi_awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_addr <= mem_axi_awaddr;
            end
            if (mem_axi_wvalid && !w_full) begin
                w_full <= 1'b1;
                w_data <= mem_axi_wdata;
                w_strb <= mem_axi_wstrb;
            end
            if (mem_axi_arvalid && !ar_full) begin
                ar_full <= 1'b1;
                ar_addr <= mem_axi_araddr;
            end
            if (mem_axi_bvalid && mem_axi_bready) begin
                mem_axi_bvalid <= 1'b0;
            end
            if (mem_axi_rvalid && mem_axi_rready) begin
                mem_axi_rvalid <= 1'b0;
            end
            if (wr_elig && rd_elig) begin
                prio_rd <= !prio_rd;
            end
            case (grant)
                GRANT_WR: begin
                    aw_full        <= 1'b0;
                    w_full         <= 1'b0;
                    mem_axi_bvalid <= 1'b1;
                    mem_axi_bresp  <= wr_hit ? RESP_OKAY : RESP_DECERR;
                end
                GRANT_RD: begin
                    ar_full        <= 1'b0;
                    mem_axi_rvalid <= 1'b1;
                    mem_axi_rresp  <= rd_hit ? RESP_OKAY : RESP_DECERR;
                    r_hit          <= rd_hit;
                end
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_axi_awprot, mem_axi_arprot,
                           wr_off[1:0], rd_off[1:0], wr_off[31:AW+2], rd_off[31:AW+2]};

endmodule

// File: doc/picorv32_axi_sram.md
# picorv32_axi_sram

AXI4-lite slave that terminates the CPU wrapper's AXI4-lite master port and backs it with an on-chip single-port 32-bit SRAM. Sits directly downstream of the core's AXI adapter: it consumes AW/W/AR, produces B/R, and serves both instruction fetches and data accesses. Independent AW and W capture buffers, a one-cycle read pipeline and a round-robin read/write arbiter give real handshake and ordering behaviour.

## Interface
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to 4*MEM_WORDS.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_axi_awvalid` in 1 / `mem_axi_awready` out 1 / `mem_axi_awaddr` in 32 / `mem_axi_awprot` in 3: write address channel.
- `mem_axi_wvalid` in 1 / `mem_axi_wready` out 1 / `mem_axi_wdata` in 32 / `mem_axi_wstrb` in 4: write data channel.
- `mem_axi_bvalid` out 1 / `mem_axi_bready` in 1 / `mem_axi_bresp` out 2: write response.
- `mem_axi_arvalid` in 1 / `mem_axi_arready` out 1 / `mem_axi_araddr` in 32 / `mem_axi_arprot` in 3: read address.
- `mem_axi_rvalid` out 1 / `mem_axi_rready` in 1 / `mem_axi_rdata` out 32 / `mem_axi_rresp` out 2: read data.

## Operation
- AW buffer (addr) and W buffer (data, strb), one entry each; `awready = !aw_full`, `wready = !w_full`. Either channel may arrive first or both in the same cycle.
- AR buffer, one entry; `arready = !ar_full`.
- Write eligible: `aw_full && w_full && !bvalid`. Read eligible: `ar_full && !rvalid`.
- One SRAM access per cycle. Both eligible: winner chosen by `prio_rd` (reset 0 = write wins); `prio_rd` toggles after every contested cycle. An uncontested access leaves `prio_rd` unchanged.
- Write access: bytes with `wstrb[i]=1` updated; AW/W buffers cleared; `bvalid` set, `bresp` = OKAY.
- Read access: word read into `rdata`; AR buffer cleared; `rvalid` set, `rresp` = OKAY.
- `bvalid` clears on `bvalid && bready`; `rvalid` clears on `rvalid && rready`; `rdata`/`rresp`/`bresp` hold until then.
- Word index = `(addr - BASE_ADDR) >> 2`, low two address bits ignored; `*prot` accepted and ignored.
- `wstrb = 4'b0000`: no bytes written, OKAY response still issued.

## Timing
- Reset values: `awready=1`, `wready=1`, `arready=1`, `bvalid=0`, `rvalid=0`, `bresp=0`, `rresp=0`, `rdata=0`, `prio_rd=0`, all buffers empty. SRAM contents are not reset.
- Reset asserted mid-transaction: buffers and pending responses dropped immediately; partially collected writes never reach SRAM.
- Write: AW and W handshakes complete by edge E; access at E+1; `bvalid` high from E+1. Read: AR handshake at E; access at E+1; `rvalid`/`rdata` valid from E+1.
- Contention delays the loser by exactly one cycle.
- Sustained throughput with ready held high: one read per 2 cycles, one write per 2 cycles.
- Read after write to the same word, write granted first: read returns new data.

## Configuration
- `PICORV32_AXI_SRAM_DECERR_EN` defined: addresses outside `[BASE_ADDR, BASE_ADDR + 4*MEM_WORDS)` never touch SRAM; writes respond `bresp=2'b11`, reads respond `rresp=2'b11` with `rdata=0`; handshake timing unchanged.
- Undefined: address offset is taken modulo `4*MEM_WORDS` (aliasing); responses are always OKAY.

## Structure
- Package `picorv32_axi_sram_pkg`: response constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`; arbiter grant enum (NONE, WR, RD).
- Sub-module `picorv32_axi_sram_array`: single-port byte-strobed synchronous RAM (en, we[3:0], addr, wdata, registered rdata). Buffers, arbiter and response logic stay in the top level.

## Test plan
- Reset, then AW+W same cycle to 0x10, data 0xDEADBEEF, strb 4'hF; AR 0x10 -> `bvalid` at E+1 with OKAY; later `rdata=0xDEADBEEF`, OKAY.
- W presented 3 cycles before AW (addr 0x20, strb 4'b0101, data 0x11223344 over prior 0xAAAAAAAA) -> `wready` low while waiting; readback `0xAA22AA44`.
- Write and read eligible in the same cycle, twice -> first contest grants write, second grants read; loser's response is one cycle late each time.
- Hold `bready=0` for 5 cycles after a write, present a second AW/W -> both are buffered, `awready`/`wready` low, no second access until B handshakes; second `bvalid` follows one cycle later.
- `reset` pulsed with a read accepted and `rvalid` pending -> `rvalid=0`, `arready=1` immediately; prior SRAM contents intact on re-read.
- With `_DECERR_EN`, MEM_WORDS=1024, read 0x1000 and write 0x1004 -> `rresp=2'b11`, `rdata=0`, `bresp=2'b11`, word 1 unchanged; without the macro, 0x1004 aliases to word 1.
